pc_fetch_unit: RTL and testbench

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_unit_pkg.sv | 19 +
 rtl/pc_fetch_unit_if.sv | 27 ++
 rtl/fetch_timer.sv | 27 ++
 rtl/pc_fetch_unit.sv | 94 +++++++++
 tb/tb_pc_fetch_unit.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and widths for the PC fetch unit and its timeout timer.
package pc_fetch_unit_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 16;
    localparam int CNT_W   = 16;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        HOLD,
        HALTED
    } fetch_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == '1) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory bus plus fetch/decode handshake of the PC fetch unit.
interface pc_fetch_unit_if;
    import pc_fetch_unit_pkg::*;

    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_data;
    logic [PC_W-1:0]    address;
    logic [INSTR_W-1:0] instruction;
    logic               instr_valid;
    logic               instr_ready;
    logic [PC_W-1:0]    new_pc;
    logic               halt_req;

    // The fetch unit is the master; memory and the downstream stage form the slave side.
    modport master (
        output imem_req, imem_addr, address, instruction, instr_valid,
        input  imem_ack, imem_data, instr_ready, new_pc, halt_req
    );

    modport slave (
        input  imem_req, imem_addr, address, instruction, instr_valid,
        output imem_ack, imem_data, instr_ready, new_pc, halt_req
    );

endinterface

// File: rtl/fetch_timer.sv
// Cycle counter bounding how long an instruction fetch may wait for its ack.
module fetch_timer
    import pc_fetch_unit_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    logic [CNT_W-1:0] r_count;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: requests the word at the current PC, holds it for decode, then advances to new_pc.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 8'h00,
    parameter int              TIMEOUT  = 16
) (
    input  logic              clk,
    input  logic              reset,
    pc_fetch_unit_if.master   bus,
    output logic              o_fetch_err,
    output logic [CNT_W-1:0]  o_retired_count
);

    fetch_state_t       r_state;
    logic [PC_W-1:0]    r_address;
    logic [INSTR_W-1:0] r_instruction;
    logic               r_fetch_err;
    logic [CNT_W-1:0]   r_retired_count;

    logic w_handshake;
    logic w_timer_clear;
    logic w_timer_enable;
    logic w_timer_expired;

    assign w_handshake    = (r_state == HOLD) && bus.instr_ready;
    assign w_timer_clear  = w_handshake && !bus.halt_req;
    // Counting starts in FETCH so expiry lands after exactly TIMEOUT unacknowledged request cycles.
    assign w_timer_enable = (r_state == FETCH) || (r_state == WAIT);

    fetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_fetch_timer (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_timer_clear),
        .i_enable  (w_timer_enable),
        .o_expired (w_timer_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= FETCH;
            r_address       <= RESET_PC;
            r_instruction   <= '0;
            r_fetch_err     <= 1'b0;
            r_retired_count <= '0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (bus.imem_ack) begin
                        r_instruction <= bus.imem_data;
                        r_state       <= HOLD;
                    end else begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    // A late ack still wins over an expiry in the same cycle.
                    if (bus.imem_ack) begin
                        r_instruction <= bus.imem_data;
                        r_state       <= HOLD;
                    end else if (w_timer_expired) begin
                        r_fetch_err <= 1'b1;
                        r_state     <= HALTED;
                    end
                end
                HOLD: begin
                    if (bus.instr_ready) begin
                        r_address       <= bus.new_pc;
                        r_retired_count <= sat_inc(r_retired_count);
                        r_state         <= bus.halt_req ? HALTED : FETCH;
                    end
                end
                HALTED: begin
                    r_state <= HALTED;
                end
                default: begin
                    r_state <= FETCH;
                end
            endcase
        end
    end

    // Outputs are decoded from state or driven straight from registers; nothing depends on instr_ready.
    assign bus.imem_req    = (r_state == FETCH) || (r_state == WAIT);
    assign bus.imem_addr   = r_address;
    assign bus.address     = r_address;
    assign bus.instruction = r_instruction;
    assign bus.instr_valid = (r_state == HOLD);
    assign o_fetch_err     = r_fetch_err;
    assign o_retired_count = r_retired_count;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized self-checking bench for pc_fetch_unit against a transaction-level model.
module tb_pc_fetch_unit;
    import pc_fetch_unit_pkg::*;

    localparam logic [7:0] RESET_PC = 8'h00;
    localparam int         TIMEOUT  = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_err;
    logic [15:0] retired_count;

    pc_fetch_unit_if bus();

    pc_fetch_unit #(
        .RESET_PC (RESET_PC),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .bus             (bus),
        .o_fetch_err     (fetch_err),
        .o_retired_count (retired_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Transaction-level model: where the PC is, what was fetched, how many retired, whether stopped.
    logic [7:0]  exp_pc;
    logic [15:0] exp_instr;
    logic [15:0] exp_cnt;
    logic        exp_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.imem_ack    = 1'b0;
        bus.instr_ready = 1'b0;
        bus.halt_req    = 1'b0;
    endtask

    task automatic do_reset(input bit ack_in);
        reset           = 1'b1;
        bus.imem_ack    = ack_in;
        bus.imem_data   = 16'($urandom);
        bus.instr_ready = 1'b1;
        bus.halt_req    = 1'b1;
        bus.new_pc      = 8'($urandom);
        tick();
        reset = 1'b0;
        idle_inputs();
        exp_pc    = RESET_PC;
        exp_instr = 16'h0000;
        exp_cnt   = 16'h0000;
        exp_err   = 1'b0;
        check("rst_req",   bus.imem_req,    1);
        check("rst_addr",  bus.address,     exp_pc);
        check("rst_valid", bus.instr_valid, 0);
        check("rst_instr", bus.instruction, exp_instr);
        check("rst_err",   fetch_err,       0);
        check("rst_cnt",   retired_count,   exp_cnt);
    endtask

    // One instruction: ack after `delay` extra request cycles, ready after `hold` extra HOLD cycles.
    task automatic fetch_one(input int delay, input int hold, input logic [7:0] npc,
                             input bit halt, input logic [15:0] data);
        for (int i = 0; i <= delay; i++) begin
            check("req",       bus.imem_req,    1);
            check("imem_addr", bus.imem_addr,   exp_pc);
            check("addr",      bus.address,     exp_pc);
            check("valid_low", bus.instr_valid, 0);
            check("instr_old", bus.instruction, exp_instr);
            check("err_low",   fetch_err,       0);
            bus.imem_ack    = (i == delay);
            bus.imem_data   = (i == delay) ? data : 16'($urandom);
            bus.instr_ready = 1'($urandom);
            bus.halt_req    = halt | 1'($urandom);
            bus.new_pc      = 8'($urandom);
            tick();
        end
        exp_instr = data;
        for (int j = 0; j <= hold; j++) begin
            check("hold_valid", bus.instr_valid, 1);
            check("hold_req",   bus.imem_req,    0);
            check("hold_instr", bus.instruction, exp_instr);
            check("hold_addr",  bus.address,     exp_pc);
            check("hold_cnt",   retired_count,   exp_cnt);
            bus.instr_ready = (j == hold);
            bus.halt_req    = (j == hold) ? halt : 1'($urandom);
            bus.new_pc      = (j == hold) ? npc : 8'($urandom);
            bus.imem_ack    = 1'($urandom);
            bus.imem_data   = 16'($urandom);
            tick();
        end
        idle_inputs();
        exp_pc  = npc;
        exp_cnt = (exp_cnt == 16'hFFFF) ? exp_cnt : 16'(exp_cnt + 16'd1);
    endtask

    task automatic check_halted(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            check("halt_req",   bus.imem_req,    0);
            check("halt_valid", bus.instr_valid, 0);
            check("halt_addr",  bus.address,     exp_pc);
            check("halt_instr", bus.instruction, exp_instr);
            check("halt_err",   fetch_err,       exp_err);
            check("halt_cnt",   retired_count,   exp_cnt);
            bus.imem_ack    = 1'($urandom);
            bus.imem_data   = 16'($urandom);
            bus.instr_ready = 1'($urandom);
            bus.halt_req    = 1'($urandom);
            bus.new_pc      = 8'($urandom);
            tick();
        end
        idle_inputs();
    endtask

    // No ack ever: the fetch gives up after exactly TIMEOUT request cycles.
    task automatic run_timeout;
        for (int n = 0; n < TIMEOUT; n++) begin
            check("to_req",  bus.imem_req,  1);
            check("to_addr", bus.imem_addr, exp_pc);
            check("to_err",  fetch_err,     0);
            bus.imem_ack    = 1'b0;
            bus.instr_ready = 1'($urandom);
            tick();
        end
        idle_inputs();
        exp_err = 1'b1;
        check_halted(8);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        bus.imem_data = 16'h0000;
        bus.new_pc    = 8'h00;
        idle_inputs();
        tick();

        do_reset(1'b0);

        // Back-to-back two-cycle fetches from reset.
        fetch_one(0, 0, 8'h10, 1'b0, 16'h1234);
        fetch_one(0, 0, 8'h11, 1'b0, 16'hBEEF);

        // Slow memory and a stalled consumer.
        fetch_one(3, 4, 8'h12, 1'b0, 16'hA5A5);

        // Taken branch, then the PC wrap handled upstream.
        fetch_one(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), 8'h2A, 1'b0, 16'($urandom));
        fetch_one(1, 1, 8'hFF, 1'b0, 16'h0F0F);
        fetch_one(0, 2, 8'h00, 1'b0, 16'hF0F0);
        fetch_one(0, 0, 8'h05, 1'b0, 16'h5555);

        // Ack arriving on the very last request cycle before expiry.
        fetch_one(TIMEOUT - 1, 0, 8'h40, 1'b0, 16'h7777);

        for (int t = 0; t < 40; t++) begin
            fetch_one(int'($urandom_range(0, TIMEOUT - 1)), int'($urandom_range(0, 5)),
                      8'($urandom), 1'b0, 16'($urandom));
        end

        // Reset during WAIT with a simultaneous ack discards the fetched word.
        fetch_one(0, 0, 8'h60, 1'b0, 16'hC3C3);
        check("w_req0", bus.imem_req, 1);
        bus.imem_ack = 1'b0;
        tick();
        check("w_req1", bus.imem_req, 1);
        tick();
        do_reset(1'b1);

        // Halt requested while waiting; the pending fetch still retires.
        fetch_one(2, 0, 8'h33, 1'b1, 16'h4242);
        check_halted(10);

        do_reset(1'b0);
        run_timeout();

        do_reset(1'b0);
        fetch_one(0, 0, 8'h01, 1'b0, 16'h0001);
        check("final_cnt", retired_count, exp_cnt);
        check("final_req", bus.imem_req,  1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
